// File: rtl/arm7tdmi_mem_arbiter.sv
// Shares one burst-capable memory port between the IC refill master and the core data port.
// DP has fixed priority; IC is forced through after STARVE_LIMIT consecutive DP wins while it waits.
module arm7tdmi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_req,
  input  logic [2:0]            ic_burst_len,
  output logic [31:0]           ic_data,
  output logic                  ic_valid,
  output logic                  ic_ready,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  input  logic                  dp_req,
  input  logic                  dp_we,
  input  logic [31:0]           dp_wdata,
  input  logic [2:0]            dp_burst_len,
  output logic [31:0]           dp_data,
  output logic                  dp_valid,
  output logic                  dp_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic [2:0]            mem_burst_len,
  input  logic [31:0]           mem_data,
  input  logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [31:0]           ic_grants,
  output logic [31:0]           dp_grants
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned CNT_W    = 32;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, TURN} state_t;

  state_t                state_q, state_d;
  logic                  owner_dp_q, owner_dp_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0]     ic_hold_q, ic_hold_d;
  logic [DATA_W-1:0]     dp_hold_q, dp_hold_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_req_d;
  logic                  mem_we_d;
  logic [DATA_W-1:0]     mem_wdata_d;
  logic [LEN_W-1:0]      mem_burst_len_d;
  logic                  ic_ready_d, dp_ready_d;
  logic [CNT_W-1:0]      ic_grants_d, dp_grants_d;
  logic                  dp_win;
  logic                  beat_valid;

  assign dp_win     = dp_req && !(ic_req && (starve_q == STARVE_MAX));
  assign beat_valid = (state_q == BURST) && mem_valid;

  // Beats are steered to the owner in the same cycle; the last beat is held afterwards.
  assign ic_valid = beat_valid && !owner_dp_q;
  assign dp_valid = beat_valid && owner_dp_q;
  assign ic_data  = ic_valid ? mem_data : ic_hold_q;
  assign dp_data  = dp_valid ? mem_data : dp_hold_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    owner_dp_d      = owner_dp_q;
    len_d           = len_q;
    beat_d          = beat_q;
    starve_d        = starve_q;
    ic_hold_d       = ic_hold_q;
    dp_hold_d       = dp_hold_q;
    mem_addr_d      = mem_addr;
    mem_req_d       = mem_req;
    mem_we_d        = mem_we;
    mem_wdata_d     = mem_wdata;
    mem_burst_len_d = mem_burst_len;
    ic_ready_d      = ic_ready;
    dp_ready_d      = dp_ready;
    ic_grants_d     = ic_grants;
    dp_grants_d     = dp_grants;

    unique case (state_q)
      IDLE: begin
        if (!ic_req) starve_d = '0;
        if (ic_req || dp_req) begin
          state_d    = ISSUE;
          owner_dp_d = dp_win;
          mem_req_d  = 1'b1;
          ic_ready_d = 1'b0;
          dp_ready_d = 1'b0;
          if (dp_win) begin
            // Writes are always a single beat regardless of dp_burst_len
            len_d       = dp_we ? LEN_W'(0) : dp_burst_len;
            mem_addr_d  = dp_addr;
            mem_we_d    = dp_we;
            mem_wdata_d = dp_wdata;
            dp_grants_d = (dp_grants == '1) ? dp_grants : dp_grants + CNT_W'(1);
            if (ic_req && (starve_q < STARVE_MAX)) starve_d = starve_q + STARVE_W'(1);
          end else begin
            len_d       = ic_burst_len;
            mem_addr_d  = ic_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            ic_grants_d = (ic_grants == '1) ? ic_grants : ic_grants + CNT_W'(1);
            starve_d    = '0;
          end
          mem_burst_len_d = dp_win ? (dp_we ? LEN_W'(0) : dp_burst_len) : ic_burst_len;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d         = BURST;
          beat_d          = '0;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          mem_addr_d      = '0;
          mem_wdata_d     = '0;
          mem_burst_len_d = '0;
        end
      end
      BURST: begin
        if (mem_valid) begin
          beat_d = beat_q + LEN_W'(1);
          if (owner_dp_q) dp_hold_d = mem_data;
          else            ic_hold_d = mem_data;
          if (beat_q == len_q) state_d = TURN;
        end
      end
      TURN: begin
        state_d    = IDLE;
        ic_ready_d = 1'b1;
        dp_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_dp_q    <= 1'b0;
      len_q         <= '0;
      beat_q        <= '0;
      starve_q      <= '0;
      ic_hold_q     <= '0;
      dp_hold_q     <= '0;
      mem_addr      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_burst_len <= '0;
      ic_ready      <= 1'b1;
      dp_ready      <= 1'b1;
      ic_grants     <= '0;
      dp_grants     <= '0;
    end else begin
      state_q       <= state_d;
      owner_dp_q    <= owner_dp_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      starve_q      <= starve_d;
      ic_hold_q     <= ic_hold_d;
      dp_hold_q     <= dp_hold_d;
      mem_addr      <= mem_addr_d;
      mem_req       <= mem_req_d;
      mem_we        <= mem_we_d;
      mem_wdata     <= mem_wdata_d;
      mem_burst_len <= mem_burst_len_d;
      ic_ready      <= ic_ready_d;
      dp_ready      <= dp_ready_d;
      ic_grants     <= ic_grants_d;
      dp_grants     <= dp_grants_d;
    end
  end

endmodule

// File: tb/tb_arm7tdmi_mem_arbiter.sv
// Self-checking bench for arm7tdmi_mem_arbiter: memory responder, transaction-level
// arbitration model checked every cycle, plus directed scenarios with literal expectations.
module tb_arm7tdmi_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned LIMIT = 4;
  localparam int PH_IDLE = 0, PH_CMD = 1, PH_BURST = 2, PH_TURN = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ic_addr, dp_addr, mem_addr;
  logic          ic_req, dp_req, dp_we;
  logic [2:0]    ic_burst_len, dp_burst_len, mem_burst_len;
  logic [31:0]   ic_data, dp_data, dp_wdata, mem_wdata, mem_data;
  logic          ic_valid, ic_ready, dp_valid, dp_ready;
  logic          mem_req, mem_we, mem_valid, mem_ready;
  logic [31:0]   ic_grants, dp_grants;

  arm7tdmi_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_addr(ic_addr), .ic_req(ic_req), .ic_burst_len(ic_burst_len),
    .ic_data(ic_data), .ic_valid(ic_valid), .ic_ready(ic_ready),
    .dp_addr(dp_addr), .dp_req(dp_req), .dp_we(dp_we), .dp_wdata(dp_wdata),
    .dp_burst_len(dp_burst_len), .dp_data(dp_data), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_burst_len(mem_burst_len), .mem_data(mem_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .ic_grants(ic_grants), .dp_grants(dp_grants)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: word index tagged with 0xDEAD in the upper half
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int b);
    logic [31:0] w;
    w = (a >> 2) + 32'(b);
    return 32'hDEAD0000 | {16'h0000, w[15:0]};
  endfunction

  // Memory responder: always ready, returns beats starting the cycle after the handshake
  bit gap_mode     = 1'b0;
  bit inject_stray = 1'b0;
  initial begin : responder
    logic [31:0] r_addr;
    int          r_n;
    mem_valid = 1'b0;
    mem_data  = '0;
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && mem_ready) begin
        r_addr = mem_addr;
        r_n    = mem_we ? 1 : int'(mem_burst_len) + 1;
        @(posedge clk); #1;
        for (int b = 0; b < r_n; b++) begin
          mem_valid = 1'b1;
          mem_data  = mem_word(r_addr, b);
          @(posedge clk); #1;
          mem_valid = 1'b0;
          if (gap_mode) begin @(posedge clk); #1; end
        end
      end else if (inject_stray) begin
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_data  = 32'h5555AAAA;
        @(posedge clk); #1;
        mem_valid = 1'b0;
      end
    end
  end

  // Model state (transaction timeline derived from the arbitration rules)
  int            m_ph;
  bit            m_own_dp;
  int unsigned   m_starve;
  logic [31:0]   m_icg, m_dpg, m_ic_hold, m_dp_hold;
  logic [31:0]   q[$];
  logic [31:0]   e_addr, e_wd;
  logic [2:0]    e_len;
  logic          e_we;
  bit            p_last;
  logic          p_ic_req, p_dp_req, p_dp_we;
  logic [31:0]   p_ic_addr, p_dp_addr, p_dp_wdata;
  logic [2:0]    p_ic_len, p_dp_len;
  int            n_ic_beats = 0, n_dp_beats = 0, n_stray = 0;
  logic [31:0]   last_ic_data, last_dp_data, last_addr, last_wd;
  logic [2:0]    last_len;
  logic          last_we;

  initial begin : compare
    logic [31:0] e;
    bit exp_icv, exp_dpv;
    m_ph = PH_IDLE; m_starve = 0; m_icg = '0; m_dpg = '0;
    m_ic_hold = '0; m_dp_hold = '0; p_last = 0; m_own_dp = 0;
    p_ic_req = 0; p_dp_req = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ph = PH_IDLE; m_starve = 0; m_icg = '0; m_dpg = '0;
        m_ic_hold = '0; m_dp_hold = '0; q.delete(); p_last = 0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_len", mem_burst_len, 0);
        chk("rst_ic_ready", ic_ready, 1);
        chk("rst_dp_ready", dp_ready, 1);
        chk("rst_ic_valid", ic_valid, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_ic_data", ic_data, 0);
        chk("rst_dp_data", dp_data, 0);
        chk("rst_ic_grants", ic_grants, 0);
        chk("rst_dp_grants", dp_grants, 0);
      end else begin
        case (m_ph)
          PH_IDLE: begin
            if (p_ic_req || p_dp_req) begin
              m_own_dp = p_dp_req && !(p_ic_req && m_starve == LIMIT);
              if (m_own_dp) begin
                m_starve = p_ic_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                m_dpg    = (m_dpg == 32'hFFFFFFFF) ? m_dpg : m_dpg + 1;
                e_addr = p_dp_addr; e_we = p_dp_we; e_wd = p_dp_wdata;
                e_len  = p_dp_we ? 3'd0 : p_dp_len;
              end else begin
                m_starve = 0;
                m_icg    = (m_icg == 32'hFFFFFFFF) ? m_icg : m_icg + 1;
                e_addr = p_ic_addr; e_we = 1'b0; e_wd = '0; e_len = p_ic_len;
              end
              for (int b = 0; b <= int'(e_len); b++) q.push_back(mem_word(e_addr, b));
              m_ph = PH_CMD;
            end else begin
              m_starve = 0;
            end
          end
          PH_CMD:   m_ph = PH_BURST;
          PH_BURST: if (p_last) m_ph = PH_TURN;
          default:  m_ph = PH_IDLE;
        endcase
        p_last = 0;

        chk("ic_ready", ic_ready, m_ph == PH_IDLE);
        chk("dp_ready", dp_ready, m_ph == PH_IDLE);
        chk("mem_req", mem_req, m_ph == PH_CMD);
        chk("ic_grants", ic_grants, m_icg);
        chk("dp_grants", dp_grants, m_dpg);
        if (m_ph == PH_CMD) begin
          chk("mem_addr", mem_addr, e_addr);
          chk("mem_we", mem_we, e_we);
          if (e_we) chk("mem_wdata", mem_wdata, e_wd);
          else      chk("mem_burst_len", mem_burst_len, e_len);
          last_addr = mem_addr; last_we = mem_we; last_wd = mem_wdata; last_len = mem_burst_len;
        end else begin
          chk("mem_we_idle", mem_we, 0);
        end

        if (mem_valid && m_ph != PH_BURST) n_stray++;
        exp_icv = (m_ph == PH_BURST) && !m_own_dp && mem_valid;
        exp_dpv = (m_ph == PH_BURST) &&  m_own_dp && mem_valid;
        chk("ic_valid", ic_valid, exp_icv);
        chk("dp_valid", dp_valid, exp_dpv);
        if ((exp_icv || exp_dpv) && q.size() > 0) begin
          e = q.pop_front();
          if (exp_icv) begin
            chk("ic_data_beat", ic_data, e);
            m_ic_hold = e; last_ic_data = ic_data; n_ic_beats++;
          end else begin
            chk("dp_data_beat", dp_data, e);
            m_dp_hold = e; last_dp_data = dp_data; n_dp_beats++;
          end
          if (q.size() == 0) p_last = 1;
        end
        if (!exp_icv) chk("ic_data_hold", ic_data, m_ic_hold);
        if (!exp_dpv) chk("dp_data_hold", dp_data, m_dp_hold);
      end
      p_ic_req = ic_req; p_ic_addr = ic_addr; p_ic_len = ic_burst_len;
      p_dp_req = dp_req; p_dp_addr = dp_addr; p_dp_len = dp_burst_len;
      p_dp_we = dp_we; p_dp_wdata = dp_wdata;
    end
  end

  // Masters hold their request until their own grant counter advances
  task automatic ic_issue(input logic [31:0] a, input logic [2:0] l);
    logic [31:0] g0;
    g0 = ic_grants;
    ic_addr = a; ic_burst_len = l; ic_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (ic_grants != g0) break;
    end
    chk("ic_grant_timeout", 32'(ic_grants != g0), 1);
    ic_req = 1'b0;
  endtask

  task automatic dp_issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [2:0] l);
    logic [31:0] g0;
    g0 = dp_grants;
    dp_addr = a; dp_we = we; dp_wdata = wd; dp_burst_len = l; dp_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (dp_grants != g0) break;
    end
    chk("dp_grant_timeout", 32'(dp_grants != g0), 1);
    dp_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ic_ready && dp_ready) begin ok = 1; break; end
    end
    chk("idle_timeout", 32'(ok), 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b_ic, b_dp, b_st;
    rst_n = 1'b0; ic_req = 0; dp_req = 0; dp_we = 0;
    ic_addr = '0; dp_addr = '0; dp_wdata = '0; ic_burst_len = '0; dp_burst_len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // IC-only 8-beat burst with gaps between beats
    gap_mode = 1; b_ic = n_ic_beats; b_dp = n_dp_beats;
    ic_issue(32'h1000, 3'd7);
    wait_idle();
    gap_mode = 0;
    chk("t1_mem_addr", last_addr, 32'h1000);
    chk("t1_mem_len", 32'(last_len), 7);
    chk("t1_ic_beats", n_ic_beats - b_ic, 8);
    chk("t1_dp_beats", n_dp_beats - b_dp, 0);
    chk("t1_last_ic_data", last_ic_data, 32'hDEAD0407);
    chk("t1_ic_grants", ic_grants, 1);

    // DP single write; burst length must be ignored
    do_reset(); b_ic = n_ic_beats; b_dp = n_dp_beats;
    dp_issue(32'h2000, 1'b1, 32'hCAFEF00D, 3'd5);
    wait_idle();
    chk("t2_mem_addr", last_addr, 32'h2000);
    chk("t2_mem_we", 32'(last_we), 1);
    chk("t2_mem_wdata", last_wd, 32'hCAFEF00D);
    chk("t2_dp_beats", n_dp_beats - b_dp, 1);
    chk("t2_ic_beats", n_ic_beats - b_ic, 0);

    // Simultaneous requests: DP first, IC stays pending
    do_reset(); b_ic = n_ic_beats; b_dp = n_dp_beats;
    fork
      ic_issue(32'h1000, 3'd3);
      begin
        dp_issue(32'h3000, 1'b0, 32'h0, 3'd0);
        chk("t3_icg_at_dp_grant", ic_grants, 0);
      end
    join
    wait_idle();
    chk("t3_dp_data", last_dp_data, 32'hDEAD0C00);
    chk("t3_ic_data", last_ic_data, 32'hDEAD0403);
    chk("t3_dp_beats", n_dp_beats - b_dp, 1);
    chk("t3_ic_beats", n_ic_beats - b_ic, 4);
    chk("t3_ic_grants", ic_grants, 1);
    chk("t3_dp_grants", dp_grants, 1);

    // Starvation override: IC wins after LIMIT back-to-back DP grants
    do_reset();
    fork
      begin
        ic_issue(32'h1800, 3'd1);
        chk("t4_dpg_at_ic_grant", dp_grants, 4);
      end
      for (int i = 0; i < 6; i++) dp_issue(32'h4000 + 32'(i * 4), 1'b0, 32'h0, 3'd0);
    join
    wait_idle();
    chk("t4_dp_grants", dp_grants, 6);
    chk("t4_ic_grants", ic_grants, 1);

    // Reset after 3 of 8 IC beats, then a normal DP read
    do_reset(); b_ic = n_ic_beats;
    ic_issue(32'h1000, 3'd7);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (n_ic_beats - b_ic >= 3) break;
    end
    chk("t5_beats_before_reset", n_ic_beats - b_ic, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_ic_ready", ic_ready, 1);
    chk("t5_dp_ready", dp_ready, 1);
    chk("t5_ic_grants", ic_grants, 0);
    chk("t5_ic_valid", ic_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("t5_ic_beats_after", n_ic_beats - b_ic, 3);
    b_dp = n_dp_beats;
    dp_issue(32'h5000, 1'b0, 32'h0, 3'd2);
    wait_idle();
    chk("t5_dp_beats", n_dp_beats - b_dp, 3);
    chk("t5_dp_data", last_dp_data, 32'hDEAD1402);
    chk("t5_dp_grants", dp_grants, 1);

    // Stray beat while idle is ignored
    b_ic = n_ic_beats; b_dp = n_dp_beats; b_st = n_stray;
    inject_stray = 1;
    @(posedge clk); #1;
    inject_stray = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_stray_seen", n_stray - b_st, 1);
    chk("t6_ic_beats", n_ic_beats - b_ic, 0);
    chk("t6_dp_beats", n_dp_beats - b_dp, 0);
    chk("t6_ic_ready", ic_ready, 1);
    chk("t6_dp_ready", dp_ready, 1);
    chk("t6_mem_req", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_mem_arbiter.md
Name: arm7tdmi_mem_arbiter

Overview:
Shares the single burst-capable external memory port between the instruction cache refill master (IC) and the core data port (DP).
- Arbitrates requests and forwards the granted master's command to memory.
- Counts returned beats and steers read data and valid pulses back to the owner only.
- Uses fixed DP priority, with an anti-starvation override for IC.
- Sits between arm7tdmi_icache / core load-store unit and the memory model or bus bridge.

Parameters:
ADDR_WIDTH, 32, address width of all ports
STARVE_LIMIT, 4, consecutive DP grants while IC is pending before IC is forced to win (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ic_addr  in  ADDR_WIDTH  IC burst start address (word aligned)
ic_req  in  1  IC request; held with addr/len stable until ic_ready falls
ic_burst_len  in  3  IC beats minus one (0..7)
ic_data  out  32  read data to IC
ic_valid  out  1  IC read beat strobe
ic_ready  out  1  high when arbiter can accept an IC request
dp_addr  in  ADDR_WIDTH  DP address
dp_req  in  1  DP request
dp_we  in  1  DP write (single beat; burst_len ignored)
dp_wdata  in  32  DP write data
dp_burst_len  in  3  DP read beats minus one
dp_data  out  32  read data to DP
dp_valid  out  1  DP beat strobe (one pulse acks a write)
dp_ready  out  1  high when arbiter can accept a DP request
mem_addr  out  ADDR_WIDTH  memory address
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_wdata  out  32  memory write data
mem_burst_len  out  3  memory beats minus one
mem_data  in  32  memory read data
mem_valid  in  1  memory beat strobe
mem_ready  in  1  memory idle/accepting
ic_grants  out  32  IC transactions granted (saturating)
dp_grants  out  32  DP transactions granted (saturating)

Behaviour:
- Reset (async, any state): FSM=IDLE. All mem_* outputs 0. ic_valid=dp_valid=0, ic_data=dp_data=0, ic_ready=dp_ready=1. Counters 0, starve count 0. Reset mid-burst abandons the transaction; remaining mem_valid beats after reset are ignored.
- FSM states: IDLE, ISSUE, BURST, TURN.
- IDLE:
  - If any req, register winner, address, len, we, wdata; go ISSUE next cycle.
  - Winner = DP if dp_req and not (ic_req and starve_cnt==STARVE_LIMIT); else IC.
  - Winner's ready drops the cycle after sampling.
  - Loser's ready also drops while the arbiter is busy.
  - Increment the winner's grant counter.
- starve_cnt:
  - +1 when DP wins while ic_req is high.
  - Cleared when IC wins or ic_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- ISSUE: mem_req=1 with registered fields; mem_we=1 only for a DP write. On the first cycle where mem_req&&mem_ready, drop mem_req next cycle, clear beat_cnt, go BURST.
- BURST:
  - Each mem_valid: forward mem_data to owner's data port the same cycle (combinational steer, registered data held after) and pulse owner's valid; increment beat_cnt.
  - Exit when the beat with beat_cnt==len arrives (write: first mem_valid); go TURN.
  - Non-owner valid is never asserted.
- TURN: one idle cycle; both ready=1 next cycle; back to IDLE.
- Minimum request-to-request spacing is 4 cycles.
- Simultaneous requests in IDLE: exactly one grant. The other request stays pending and is evaluated in the next IDLE.
- Request dropped after sampling: the transaction still completes; beats are delivered.
- mem_valid outside BURST is ignored.
- Grant counters saturate at 0xFFFFFFFF.
- burst_len 7 yields 8 beats; beat_cnt is 3 bits with no overflow.

Test Plan:
- IC only: ic_addr=0x1000, len=7 → mem_addr=0x1000, len=7; 8 ic_valid pulses with data 0xDEAD0400..0xDEAD0407; dp_valid never high; ic_grants=1.
- DP write: dp_addr=0x2000, we=1, wdata=0xCAFEF00D → mem_we=1, mem_wdata=0xCAFEF00D; one dp_valid; no ic_valid.
- Simultaneous ic_req and dp_req (DP read len 0 @0x3000) → DP served first (one dp_valid = 0xDEAD0C00); IC served next; ic_grants=1, dp_grants=1.
- Starvation: ic_req held high, dp_req reissued continuously, STARVE_LIMIT=4 → 4 DP grants, then IC granted; ic_grants=1, dp_grants=4 at that point.
- Reset mid-burst: assert rst_n=0 after 3 of 8 IC beats → immediately mem_req=0, ready=1, counters 0; after release a new DP request completes normally.
- Late beat: mem_valid pulses while in IDLE → no ic_valid/dp_valid; FSM stays IDLE.
